hbus_burst_target: RTL and testbench
====================================

HBUS_BURST_TARGET -- requirements
Module: hbus_burst_target

Interface
REQ-001 SHALL have parameter DW, default IfWidth (8): hdata width in bits.
REQ-002 SHALL have parameter AW, default IfWidth (8): haddr width in bits.
REQ-003 SHALL have parameter DEPTH, default 16: number of DW-bit registers, 2..2**AW.
REQ-004 SHALL have parameter MAX_BURST, default 8: maximum beats per transaction, >=1.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port hen  input  1  transaction enable, held high for the whole burst.
REQ-008 SHALL have port hwr_rd  input  1  1=write, 0=read, sampled at transaction start.
REQ-009 SHALL have port haddr  input  AW  start address, sampled at transaction start.
REQ-010 SHALL have port hdata  inout  DW  master drives it on writes; target drives it on reads, else high-Z.
REQ-011 SHALL have port busy  output  1  high while the state is not IDLE.
REQ-012 SHALL have port err  output  1  sticky error flag for the current or last transaction.
REQ-013 SHALL have port beat_cnt  output  $clog2(MAX_BURST+1)  accepted beats in the current or last transaction.

Function
REQ-014 SHALL implement states IDLE, WR, RD and ERR.
REQ-015 In IDLE with hen=1 the block SHALL latch ptr=haddr, clear err and beat_cnt, and enter WR (hwr_rd=1) or RD (hwr_rd=0).
REQ-016 If haddr>=DEPTH at start, the block SHALL instead enter ERR with err=1, and no storage access takes place.
REQ-017 Write beats: on every edge with hen=1 from the start cycle onward, the block SHALL write hdata to mem[ptr], then ptr+=1 and beat_cnt+=1.
REQ-018 Read: hdata SHALL be driven from the cycle after the start cycle, one word mem[ptr] per cycle while in RD; ptr+=1 and beat_cnt+=1 per driven cycle.
REQ-019 The read output enable and data SHALL be registered, so hdata never glitches between beats.
REQ-020 ptr SHALL wrap from DEPTH-1 to 0 within a burst, with no error raised.
REQ-021 A beat that would exceed MAX_BURST SHALL cause entry to ERR with err=1; that beat is not written or driven.
REQ-022 WR, RD and ERR SHALL return to IDLE on the first edge that samples hen=0.
REQ-023 The target SHALL release hdata at that same edge, giving one cycle of turnaround.
REQ-024 A change of hwr_rd or haddr mid-burst SHALL be ignored.
REQ-025 In ERR, hdata SHALL stay high-Z and storage SHALL stay unchanged.
REQ-026 err and beat_cnt SHALL hold their values in IDLE until the next transaction start.
REQ-027 When hen=0 in IDLE and the next cycle brings hen=1, the block SHALL start the new transaction; back-to-back transactions need only one hen-low cycle.

Reset
REQ-028 rstn=0 SHALL asynchronously force state=IDLE, hdata to high-Z, busy=0, err=0, beat_cnt=0, ptr=0 and all registers to 0.
REQ-029 A reset mid-burst SHALL abort the burst immediately; after rstn rises, the block waits for hen=0 before accepting a new start.

Structure
REQ-030 The state enum, the DW/AW defaults (IfWidth) and the DEPTH default SHALL live in hbus_types_pkg.
REQ-031 Storage SHALL be the sub-module hbus_burst_regfile, with one write port, one read port and async reset clear.
REQ-032 The FSM, pointer, counters and tristate SHALL reside in hbus_burst_target.
REQ-033 The block SHALL contain no other clocks or latches.

Verification
REQ-034 Write burst: addr 0x03, 4 beats AA,BB,CC,DD -> regs 3..6 = AA..DD, beat_cnt=4, err=0.
REQ-035 Read burst: addr 0x03, hen high 5 cycles -> hdata = Z, AA, BB, CC, DD, then Z after hen falls.
REQ-036 Wrap: DEPTH=16, write addr 0x0E, 4 beats 11,22,33,44 -> regs 14,15,0,1 written, err=0.
REQ-037 Overlength: MAX_BURST=8, 10-beat write -> 8 regs written, err=1, beat_cnt=8, beats 9-10 dropped.
REQ-038 Bad address: haddr=0x20 with DEPTH=16 -> err=1, no write, hdata stays Z for the whole transaction.
REQ-039 Reset mid-read: rstn low on the 3rd beat -> hdata goes Z asynchronously, regs=0, and the FSM stays IDLE until a hen low-high sequence.

Source files
------------

// File: rtl/hbus_types_pkg.sv
// Shared types and defaults for the hbus burst target and its register file.
// Holds the FSM state encoding and the bus width / storage depth defaults.
package hbus_types_pkg;

  localparam int IfWidth  = 8;
  localparam int DefDepth = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    ERR  = 2'd3
  } hbus_state_e;

endpackage

// File: rtl/hbus_burst_regfile.sv
// Register storage: DEPTH words, one write port (written on the clock edge), one combinational read port.
// Latency: write lands at the edge, read is same-cycle; no backpressure, every asserted write is taken.
module hbus_burst_regfile
  import hbus_types_pkg::*;
#(
  parameter int DW    = IfWidth,
  parameter int DEPTH = DefDepth,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdat,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdat;
    end
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/hbus_burst_target.sv
// Burst target on a shared tristate data bus: writes from the start edge, reads driven from the following cycle.
// Latency: one registered word per cycle; no backpressure, overlength or bad-address bursts park in ERR until hen falls.
module hbus_burst_target
  import hbus_types_pkg::*;
#(
  parameter int DW        = IfWidth,
  parameter int AW        = IfWidth,
  parameter int DEPTH     = DefDepth,
  parameter int MAX_BURST = 8,
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hen,
  input  logic          hwr_rd,
  input  logic [AW-1:0] haddr,
  inout  wire  [DW-1:0] hdata,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] beat_cnt
);

  localparam int            IW       = $clog2(DEPTH);
  localparam int            LASTI    = DEPTH - 1;
  localparam logic [AW:0]   DEPTH_L  = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST     = LASTI[AW-1:0];
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = MAX_BURST[CW-1:0];

  hbus_state_e   state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt, cur, cur_inc;
  logic [CW-1:0] cnt_nxt;
  logic          err_nxt;
  logic          armed, armed_nxt;
  logic          rd_oe, rd_oe_nxt;
  logic [DW-1:0] rd_dat, rd_dat_nxt;
  logic          we;
  logic          addr_ok;
  logic [DW-1:0] mem_rdat;

  hbus_burst_regfile #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_regfile (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr (cur[IW-1:0]),
    .wdat  (hdata),
    .raddr (cur[IW-1:0]),
    .rdat  (mem_rdat)
  );

  // The start beat addresses storage straight from haddr; later beats use the pointer.
  assign cur     = (state == IDLE) ? haddr : ptr;
  assign cur_inc = (cur == LAST) ? '0 : cur + ADDR_ONE;
  assign addr_ok = ({1'b0, haddr} < DEPTH_L);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cnt_nxt    = beat_cnt;
    err_nxt    = err;
    armed_nxt  = armed | ~hen;
    we         = 1'b0;
    rd_oe_nxt  = 1'b0;
    rd_dat_nxt = rd_dat;
    case (state)
      IDLE: begin
        if (hen && armed) begin
          armed_nxt = 1'b0;
          ptr_nxt   = haddr;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          if (!addr_ok) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end else begin
            state_nxt  = hwr_rd ? WR : RD;
            ptr_nxt    = cur_inc;
            cnt_nxt    = CNT_ONE;
            we         = hwr_rd;
            rd_oe_nxt  = ~hwr_rd;
            rd_dat_nxt = mem_rdat;
          end
        end
      end
      WR, RD: begin
        if (!hen) begin
          state_nxt = IDLE;
        end else if (beat_cnt == CNT_MAX) begin
          // The beat past the limit is neither written nor driven.
          state_nxt = ERR;
          err_nxt   = 1'b1;
        end else begin
          ptr_nxt    = cur_inc;
          cnt_nxt    = beat_cnt + CNT_ONE;
          we         = (state == WR);
          rd_oe_nxt  = (state == RD);
          rd_dat_nxt = mem_rdat;
        end
      end
      ERR: begin
        if (!hen) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      armed    <= 1'b0;
      rd_oe    <= 1'b0;
      rd_dat   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= cnt_nxt;
      err      <= err_nxt;
      armed    <= armed_nxt;
      rd_oe    <= rd_oe_nxt;
      rd_dat   <= rd_dat_nxt;
    end
  end

  assign busy  = (state != IDLE);
  assign hdata = rd_oe ? rd_dat : {DW{1'bz}};

endmodule

// File: tb/tb_hbus_burst_target.sv
// Directed bench for hbus_burst_target: transaction-level model of storage and per-cycle bus outputs.
// The data bus is pulled high, so an undriven bus reads as 8'hFF; no test data uses that value.
module tb_hbus_burst_target;

  localparam int         DEPTH    = 16;
  localparam int         MAXB     = 8;
  localparam logic [7:0] IDLE_BUS = 8'hFF;

  logic       clk = 1'b0;
  logic       rstn, hen, hwr_rd;
  logic [7:0] haddr;
  tri1  [7:0] hdata;
  logic       tb_oe;
  logic [7:0] tb_dat;
  logic       busy, err;
  logic [3:0] beat_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [DEPTH];
  logic       m_err;
  int         m_cnt;
  logic       chk_en = 1'b0;
  logic [7:0] e_dat;
  logic       e_busy, e_err;
  int         e_cnt;
  int         cyc_k = 31;
  logic [7:0] cap [32];

  assign hdata = tb_oe ? tb_dat : 8'hzz;
  always #5 clk = ~clk;

  hbus_burst_target #(
    .DW        (8),
    .AW        (8),
    .DEPTH     (DEPTH),
    .MAX_BURST (MAXB)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .hen      (hen),
    .hwr_rd   (hwr_rd),
    .haddr    (haddr),
    .hdata    (hdata),
    .busy     (busy),
    .err      (err),
    .beat_cnt (beat_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cap[cyc_k] = hdata;
    if (chk_en) begin
      chk("hdata", 32'(hdata), 32'(e_dat));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("err", 32'(err), 32'(e_err));
      chk("beat_cnt", 32'(beat_cnt), 32'(e_cnt));
    end
  end

  // One transaction: hen high for n cycles, then one hen-low cycle. Cycle k is the k-th
  // cycle after the first hen-high cycle; outputs in cycle k follow from k beats sampled.
  task automatic xact(input bit w, input int a, input int n, input int base);
    bit bad_a;
    int nb;
    bad_a = (a >= DEPTH);
    for (int k = 0; k <= n; k++) begin
      hen    = (k < n);
      hwr_rd = (k == 0) ? w : ~w;
      haddr  = (k == 0) ? 8'(a) : 8'(a ^ 8'h5A);
      tb_oe  = w && (k < n);
      tb_dat = 8'(base + k * 17);
      e_busy = (k >= 1);
      if (k == 0) begin
        e_err = m_err;
        e_cnt = m_cnt;
      end else if (bad_a) begin
        e_err = 1'b1;
        e_cnt = 0;
      end else begin
        e_err = (k > MAXB);
        e_cnt = (k > MAXB) ? MAXB : k;
      end
      if (tb_oe) e_dat = tb_dat;
      else if (!w && !bad_a && k >= 1 && k <= MAXB) e_dat = mdl[(a + k - 1) % DEPTH];
      else e_dat = IDLE_BUS;
      cyc_k  = k;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    cyc_k  = 31;
    nb     = (n > MAXB) ? MAXB : n;
    if (w && !bad_a) begin
      for (int j = 0; j < nb; j++) mdl[(a + j) % DEPTH] = 8'(base + j * 17);
    end
    m_err = bad_a ? 1'b1 : (n > MAXB);
    m_cnt = bad_a ? 0 : nb;
  endtask

  initial begin
    rstn = 1'b0; hen = 1'b0; hwr_rd = 1'b0; haddr = '0; tb_oe = 1'b0; tb_dat = '0;
    m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_cnt", 32'(beat_cnt), 32'd0);
    chk("reset_hdata", 32'(hdata), 32'(IDLE_BUS));
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    // write burst AA..DD at 3, then read it back with hen high five cycles
    xact(1'b1, 3, 4, 'hAA);
    chk("wr_cnt", 32'(beat_cnt), 32'd4);
    chk("wr_err", 32'(err), 32'd0);
    xact(1'b0, 3, 5, 0);
    chk("rd_c0", 32'(cap[0]), 32'(IDLE_BUS));
    chk("rd_c1", 32'(cap[1]), 32'hAA);
    chk("rd_c2", 32'(cap[2]), 32'hBB);
    chk("rd_c3", 32'(cap[3]), 32'hCC);
    chk("rd_c4", 32'(cap[4]), 32'hDD);
    chk("rd_release", 32'(hdata), 32'(IDLE_BUS));

    // pointer wrap at the top of storage
    xact(1'b1, 14, 4, 'h11);
    chk("wrap_cnt", 32'(beat_cnt), 32'd4);
    chk("wrap_err", 32'(err), 32'd0);
    xact(1'b0, 14, 4, 0);
    chk("wrap_r14", 32'(cap[1]), 32'h11);
    chk("wrap_r15", 32'(cap[2]), 32'h22);
    chk("wrap_r0", 32'(cap[3]), 32'h33);
    chk("wrap_r1", 32'(cap[4]), 32'h44);

    // out-of-range start address, write then read
    xact(1'b1, 32, 3, 'h55);
    chk("badaddr_err", 32'(err), 32'd1);
    chk("badaddr_cnt", 32'(beat_cnt), 32'd0);
    xact(1'b0, 32, 2, 0);
    chk("badaddr_rd_z", 32'(cap[1]), 32'(IDLE_BUS));

    // overlength write and read
    xact(1'b1, 4, 10, 'h01);
    chk("ovl_cnt", 32'(beat_cnt), 32'd8);
    chk("ovl_err", 32'(err), 32'd1);
    xact(1'b0, 4, 10, 0);
    xact(1'b0, 12, 2, 0);
    chk("ovl_dropped", 32'(cap[1]), 32'h00);
    chk("ovl_rd_cnt", 32'(beat_cnt), 32'd2);

    // reset during the third read beat
    hen = 1'b1; hwr_rd = 1'b0; haddr = 8'd3;
    @(posedge clk); #1;
    haddr = 8'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_pre", 32'(hdata), 32'(mdl[5]));
    #1 rstn = 1'b0;
    #1;
    chk("rstmid_hdata", 32'(hdata), 32'(IDLE_BUS));
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
    chk("rstmid_cnt", 32'(beat_cnt), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid_no_restart", 32'(busy), 32'd0);
    end
    hen = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 3, 4, 0);
    chk("rstmid_cleared", 32'(cap[1]), 32'h00);
    xact(1'b1, 1, 2, 'h70);
    xact(1'b0, 0, 4, 0);
    chk("post_rst_r1", 32'(cap[2]), 32'h70);
    chk("post_rst_r2", 32'(cap[3]), 32'h81);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
